// File: rtl/vga_pattern_gen.sv
// Frame-synchronous test-pattern source for vga_driver: registered RGB pixel per request.
// Optional moving box pattern enabled by defining VGA_PATTERN_BOX_EN.
module vga_pattern_gen #(
    parameter int H_DISP             = 640,
    parameter int V_DISP             = 480,
    parameter int FRAMES_PER_PATTERN = 120,
    parameter int CHECK_SHIFT        = 5
`ifdef VGA_PATTERN_BOX_EN
    ,
    parameter int BOX_SIZE           = 32
`endif
) (
    input  logic        clk_25m,
    input  logic        rst,
    input  logic [11:0] vga_xpos,
    input  logic [11:0] vga_ypos,
    input  logic        vga_request,
    input  logic        pattern_next,
    input  logic        auto_en,
    output logic [23:0] vga_data,
    output logic [2:0]  pattern_id,
    output logic        frame_start
);

    typedef enum logic [2:0] {
        BARS  = 3'd0,
        GRID  = 3'd1,
        GRAD  = 3'd2,
        CHECK = 3'd3,
        BOX   = 3'd4
    } pattern_t;

    localparam int unsigned BAR_W    = H_DISP / 8;
    localparam logic [11:0] H_LAST   = 12'(H_DISP - 1);
    localparam logic [11:0] V_LAST   = 12'(V_DISP - 1);
    localparam logic [11:0] FPP_LAST = 12'(FRAMES_PER_PATTERN - 1);

    pattern_t    state, state_next;
    logic        pending, pending_next;
    logic [11:0] frame_cnt, frame_cnt_next;
    logic        boundary, in_range, auto_wrap;
    logic [2:0]  bar_idx;
    logic [23:0] pixel;

    assign boundary   = vga_request && (vga_xpos == '0) && (vga_ypos == '0);
    assign in_range   = (vga_xpos <= H_LAST) && (vga_ypos <= V_LAST);
    assign pattern_id = state;

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            state     <= BARS;
            pending   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            frame_cnt <= frame_cnt_next;
        end
    end

    // A pulse coincident with a boundary is banked for the following boundary.
    always_comb begin
        state_next     = state;
        pending_next   = pending | pattern_next;
        frame_cnt_next = frame_cnt;
        auto_wrap      = 1'b0;
        if (!auto_en) begin
            frame_cnt_next = '0;
        end else if (boundary) begin
            if (frame_cnt == FPP_LAST) begin
                auto_wrap      = 1'b1;
                frame_cnt_next = '0;
            end else begin
                frame_cnt_next = frame_cnt + 12'd1;
            end
        end
        if (boundary) begin
            pending_next = pattern_next | auto_wrap;
            if (pending) begin
                case (state)
                    BARS:    state_next = GRID;
                    GRID:    state_next = GRAD;
                    GRAD:    state_next = CHECK;
`ifdef VGA_PATTERN_BOX_EN
                    CHECK:   state_next = BOX;
`else
                    CHECK:   state_next = BARS;
`endif
                    default: state_next = BARS;
                endcase
            end
        end
    end

`ifdef VGA_PATTERN_BOX_EN
    localparam logic [11:0] BX_MAX = 12'(H_DISP - BOX_SIZE);
    localparam logic [11:0] BY_MAX = 12'(V_DISP - BOX_SIZE);

    logic [11:0] bx, by;
    logic        dx, dy;
    logic        in_box;

    // Bounce: at an edge the direction flips and the step is taken the other way.
    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            bx <= '0;
            by <= '0;
            dx <= 1'b1;
            dy <= 1'b1;
        end else if (boundary) begin
            if (dx) begin
                if (bx >= BX_MAX) begin bx <= bx - 12'd1; dx <= 1'b0; end
                else              bx <= bx + 12'd1;
            end else begin
                if (bx == '0) begin bx <= 12'd1; dx <= 1'b1; end
                else          bx <= bx - 12'd1;
            end
            if (dy) begin
                if (by >= BY_MAX) begin by <= by - 12'd1; dy <= 1'b0; end
                else              by <= by + 12'd1;
            end else begin
                if (by == '0) begin by <= 12'd1; dy <= 1'b1; end
                else          by <= by - 12'd1;
            end
        end
    end

    assign in_box = (vga_xpos >= bx) && (vga_xpos < bx + 12'(BOX_SIZE)) &&
                    (vga_ypos >= by) && (vga_ypos < by + 12'(BOX_SIZE));
`endif

    always_comb begin
        bar_idx = '0;
        for (int unsigned k = 1; k < 8; k++) begin
            if (vga_xpos >= 12'(k * BAR_W)) bar_idx = bar_idx + 3'd1;
        end
    end

    // The boundary pixel already uses the post-advance pattern, so frames never tear.
    always_comb begin
        pixel = '0;
        if (vga_request && in_range) begin
            case (state_next)
                BARS:  pixel = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
                GRID:  pixel = ((vga_xpos[4:0] == '0) || (vga_ypos[4:0] == '0) ||
                                (vga_xpos == H_LAST) || (vga_ypos == V_LAST)) ? '1 : '0;
                GRAD:  pixel = {vga_xpos[7:0], vga_ypos[7:0], vga_xpos[7:0] ^ vga_ypos[7:0]};
                CHECK: pixel = (vga_xpos[CHECK_SHIFT] ^ vga_ypos[CHECK_SHIFT]) ? '1 : '0;
`ifdef VGA_PATTERN_BOX_EN
                BOX:   pixel = in_box ? 24'hFF8000 : 24'h000040;
`endif
                default: pixel = '0;
            endcase
        end
    end

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            vga_data    <= '0;
            frame_start <= 1'b0;
        end else begin
            vga_data    <= pixel;
            frame_start <= boundary;
        end
    end

endmodule
